// File: rtl/tpu_instr_dispatcher.sv
// Single-issue dispatcher: accepts host instructions, gates them on unit busy flags,
// and forwards each to its owning execution unit over valid/ready; handles SYNC/HALT.
module tpu_instr_dispatcher #(
    parameter logic [7:0] NOP_OP         = 8'h00,
    parameter logic [7:0] LOAD_WEIGHT_OP = 8'h01,
    parameter logic [7:0] MATMUL_OP      = 8'h02,
    parameter logic [7:0] ACTIVATE_OP    = 8'h04,
    parameter logic [7:0] SYNC_OP        = 8'hFE,
    parameter logic [7:0] HALT_OP        = 8'hFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [79:0] instr_i,
    input  logic        instr_valid_i,
    output logic        instr_ready_o,
    output logic [79:0] weight_instr_o,
    output logic        weight_valid_o,
    input  logic        weight_ready_i,
    input  logic        weight_busy_i,
    output logic [79:0] matmul_instr_o,
    output logic        matmul_valid_o,
    input  logic        matmul_ready_i,
    input  logic        matmul_busy_i,
    output logic [79:0] act_instr_o,
    output logic        act_valid_o,
    input  logic        act_ready_i,
    input  logic        act_busy_i,
    output logic        sync_done_o,
    output logic        halted_o,
    output logic        illegal_o,
    output logic [31:0] retired_cnt_o
);

    typedef enum logic [2:0] {
        StIdle,
        StDispatch,
        StIssue,
        StWaitIdle,
        StHalted
    } state_t;

    state_t      state_q;
    logic [79:0] instr_q;
    logic        weight_valid_q;
    logic        matmul_valid_q;
    logic        act_valid_q;
    logic        illegal_q;
    logic [31:0] retired_cnt_q;

    logic [7:0]  opcode;
    logic        all_idle;

    assign opcode   = instr_q[7:0];
    assign all_idle = !weight_busy_i && !matmul_busy_i && !act_busy_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            instr_q        <= '0;
            weight_valid_q <= 1'b0;
            matmul_valid_q <= 1'b0;
            act_valid_q    <= 1'b0;
            illegal_q      <= 1'b0;
            retired_cnt_q  <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (instr_valid_i) begin
                        instr_q <= instr_i;
                        state_q <= StDispatch;
                    end
                end
                // Gates are checked here too so a free unit sees valid two cycles after accept.
                StDispatch: begin
                    case (opcode)
                        NOP_OP: begin
                            retired_cnt_q <= retired_cnt_q + 32'd1;
                            state_q       <= StIdle;
                        end
                        LOAD_WEIGHT_OP: begin
                            weight_valid_q <= 1'b1;
                            state_q        <= StIssue;
                        end
                        MATMUL_OP: begin
                            matmul_valid_q <= !weight_busy_i;
                            state_q        <= StIssue;
                        end
                        ACTIVATE_OP: begin
                            act_valid_q <= !matmul_busy_i;
                            state_q     <= StIssue;
                        end
                        SYNC_OP, HALT_OP: begin
                            state_q <= StWaitIdle;
                        end
                        default: begin
                            illegal_q <= 1'b1;
                            state_q   <= StIdle;
                        end
                    endcase
                end
                // Once raised, a valid ignores the gate until the handshake completes.
                StIssue: begin
                    if (opcode == LOAD_WEIGHT_OP) begin
                        if (weight_valid_q && weight_ready_i) begin
                            weight_valid_q <= 1'b0;
                            retired_cnt_q  <= retired_cnt_q + 32'd1;
                            state_q        <= StIdle;
                        end else begin
                            weight_valid_q <= 1'b1;
                        end
                    end else if (opcode == MATMUL_OP) begin
                        if (matmul_valid_q && matmul_ready_i) begin
                            matmul_valid_q <= 1'b0;
                            retired_cnt_q  <= retired_cnt_q + 32'd1;
                            state_q        <= StIdle;
                        end else if (!weight_busy_i) begin
                            matmul_valid_q <= 1'b1;
                        end
                    end else begin
                        if (act_valid_q && act_ready_i) begin
                            act_valid_q   <= 1'b0;
                            retired_cnt_q <= retired_cnt_q + 32'd1;
                            state_q       <= StIdle;
                        end else if (!matmul_busy_i) begin
                            act_valid_q <= 1'b1;
                        end
                    end
                end
                StWaitIdle: begin
                    if (all_idle) begin
                        retired_cnt_q <= retired_cnt_q + 32'd1;
                        state_q       <= (opcode == HALT_OP) ? StHalted : StIdle;
                    end
                end
                StHalted: begin
                    state_q <= StHalted;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign instr_ready_o  = (state_q == StIdle);
    assign halted_o       = (state_q == StHalted);
    assign illegal_o      = illegal_q;
    assign retired_cnt_o  = retired_cnt_q;
    assign weight_valid_o = weight_valid_q;
    assign matmul_valid_o = matmul_valid_q;
    assign act_valid_o    = act_valid_q;
    // Weight address is {buffer_addr, acc_addr}, which lines up bit-for-bit with instr_q.
    assign weight_instr_o = instr_q;
    assign matmul_instr_o = instr_q;
    assign act_instr_o    = instr_q;
    assign sync_done_o    = (state_q == StWaitIdle) && (opcode == SYNC_OP) && all_idle;

endmodule

// File: tb/tb_tpu_instr_dispatcher.sv
// Directed bench for tpu_instr_dispatcher: walks each opcode class through its handshake.
module tb_tpu_instr_dispatcher;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [79:0] instr_i;
    logic        instr_valid_i;
    logic        instr_ready_o;
    logic [79:0] weight_instr_o;
    logic        weight_valid_o;
    logic        weight_ready_i;
    logic        weight_busy_i;
    logic [79:0] matmul_instr_o;
    logic        matmul_valid_o;
    logic        matmul_ready_i;
    logic        matmul_busy_i;
    logic [79:0] act_instr_o;
    logic        act_valid_o;
    logic        act_ready_i;
    logic        act_busy_i;
    logic        sync_done_o;
    logic        halted_o;
    logic        illegal_o;
    logic [31:0] retired_cnt_o;

    int total = 0;
    int bad   = 0;

    localparam logic [79:0] LdInstr = {24'h000010, 16'h0020, 32'd256, 8'h01};
    localparam logic [79:0] LdExp   = {40'h0000100020, 32'd256, 8'h01};
    localparam logic [79:0] MmInstr = {24'hABCDEF, 16'h1234, 32'd64, 8'h02};
    localparam logic [79:0] AcInstr = {24'h112233, 16'h4455, 32'd8, 8'h04};
    localparam logic [79:0] SyInstr = {24'h0, 16'h0, 32'd0, 8'hFE};
    localparam logic [79:0] IlInstr = {24'h0, 16'h0, 32'd0, 8'h37};
    localparam logic [79:0] NpInstr = {24'h0, 16'h0, 32'd0, 8'h00};
    localparam logic [79:0] HtInstr = {24'h0, 16'h0, 32'd0, 8'hFF};

    always #5 clk = ~clk;

    tpu_instr_dispatcher dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .instr_i        (instr_i),
        .instr_valid_i  (instr_valid_i),
        .instr_ready_o  (instr_ready_o),
        .weight_instr_o (weight_instr_o),
        .weight_valid_o (weight_valid_o),
        .weight_ready_i (weight_ready_i),
        .weight_busy_i  (weight_busy_i),
        .matmul_instr_o (matmul_instr_o),
        .matmul_valid_o (matmul_valid_o),
        .matmul_ready_i (matmul_ready_i),
        .matmul_busy_i  (matmul_busy_i),
        .act_instr_o    (act_instr_o),
        .act_valid_o    (act_valid_o),
        .act_ready_i    (act_ready_i),
        .act_busy_i     (act_busy_i),
        .sync_done_o    (sync_done_o),
        .halted_o       (halted_o),
        .illegal_o      (illegal_o),
        .retired_cnt_o  (retired_cnt_o)
    );

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; sample 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        instr_i = '0;
        instr_valid_i = 1'b0;
        weight_ready_i = 1'b0;
        weight_busy_i = 1'b0;
        matmul_ready_i = 1'b0;
        matmul_busy_i = 1'b0;
        act_ready_i = 1'b0;
        act_busy_i = 1'b0;
        step();
        step();
        chk("rst_ready", instr_ready_o, 1);
        chk("rst_wvalid", weight_valid_o, 0);
        chk("rst_mvalid", matmul_valid_o, 0);
        chk("rst_avalid", act_valid_o, 0);
        chk("rst_sync", sync_done_o, 0);
        chk("rst_halted", halted_o, 0);
        chk("rst_illegal", illegal_o, 0);
        chk("rst_cnt", retired_cnt_o, 0);
        chk("rst_payload", weight_instr_o, 0);
        rst_n = 1'b1;
        step();

        // LOAD_WEIGHT with ready already high
        instr_i = LdInstr;
        instr_valid_i = 1'b1;
        weight_ready_i = 1'b1;
        #1;
        chk("ld_accept_ready", instr_ready_o, 1);
        step();
        instr_valid_i = 1'b0;
        chk("ld_dispatch_busy", instr_ready_o, 0);
        chk("ld_n1_valid", weight_valid_o, 0);
        step();
        chk("ld_n2_valid", weight_valid_o, 1);
        chk("ld_payload", weight_instr_o, LdExp);
        step();
        chk("ld_valid_drop", weight_valid_o, 0);
        chk("ld_cnt", retired_cnt_o, 1);
        chk("ld_idle", instr_ready_o, 1);
        weight_ready_i = 1'b0;

        // MATMUL blocked by weight_busy for 5 cycles, then held 3 cycles
        weight_busy_i = 1'b1;
        instr_i = MmInstr;
        instr_valid_i = 1'b1;
        step();
        instr_valid_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("mm_gated", matmul_valid_o, 0);
            step();
        end
        weight_busy_i = 1'b0;
        chk("mm_gate_open_cycle", matmul_valid_o, 0);
        step();
        weight_busy_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("mm_hold_valid", matmul_valid_o, 1);
            chk("mm_hold_payload", matmul_instr_o, MmInstr);
            step();
        end
        matmul_ready_i = 1'b1;
        chk("mm_hs_valid", matmul_valid_o, 1);
        step();
        chk("mm_valid_drop", matmul_valid_o, 0);
        chk("mm_cnt", retired_cnt_o, 2);
        matmul_ready_i = 1'b0;
        weight_busy_i = 1'b0;

        // ACTIVATE, matmul_busy rises after valid is up
        instr_i = AcInstr;
        instr_valid_i = 1'b1;
        step();
        instr_valid_i = 1'b0;
        step();
        chk("act_valid_up", act_valid_o, 1);
        matmul_busy_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("act_hold_valid", act_valid_o, 1);
            chk("act_hold_payload", act_instr_o, AcInstr);
        end
        act_ready_i = 1'b1;
        step();
        chk("act_valid_drop", act_valid_o, 0);
        chk("act_cnt", retired_cnt_o, 3);
        act_ready_i = 1'b0;
        matmul_busy_i = 1'b0;

        // SYNC with act_busy for 4 cycles
        act_busy_i = 1'b1;
        instr_i = SyInstr;
        instr_valid_i = 1'b1;
        step();
        instr_valid_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("sync_wait", sync_done_o, 0);
            step();
        end
        act_busy_i = 1'b0;
        #1;
        chk("sync_pulse", sync_done_o, 1);
        chk("sync_not_ready", instr_ready_o, 0);
        step();
        chk("sync_pulse_end", sync_done_o, 0);
        chk("sync_ready_next", instr_ready_o, 1);
        chk("sync_cnt", retired_cnt_o, 4);

        // Illegal opcode then NOP
        instr_i = IlInstr;
        instr_valid_i = 1'b1;
        step();
        instr_valid_i = 1'b0;
        step();
        chk("ill_set", illegal_o, 1);
        chk("ill_cnt", retired_cnt_o, 4);
        instr_i = NpInstr;
        instr_valid_i = 1'b1;
        step();
        instr_valid_i = 1'b0;
        step();
        chk("nop_cnt", retired_cnt_o, 5);
        chk("ill_sticky", illegal_o, 1);
        chk("nop_idle", instr_ready_o, 1);

        // HALT with instr_valid held high
        instr_i = HtInstr;
        instr_valid_i = 1'b1;
        step();
        step();
        step();
        chk("halt_halted", halted_o, 1);
        chk("halt_cnt", retired_cnt_o, 6);
        instr_i = LdInstr;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("halt_stays", halted_o, 1);
            chk("halt_not_ready", instr_ready_o, 0);
            chk("halt_no_valid", weight_valid_o, 0);
        end
        rst_n = 1'b0;
        #1;
        chk("rst2_halted", halted_o, 0);
        chk("rst2_illegal", illegal_o, 0);
        chk("rst2_cnt", retired_cnt_o, 0);
        chk("rst2_ready", instr_ready_o, 1);
        chk("rst2_payload", matmul_instr_o, 0);
        step();
        rst_n = 1'b1;
        instr_i = NpInstr;
        step();
        instr_valid_i = 1'b0;
        step();
        chk("resume_cnt", retired_cnt_o, 1);
        chk("resume_idle", instr_ready_o, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
